// File: rtl/button_conditioner.sv
// button_conditioner
//   Turns the raw BUTTON pad into a debounced level, single-cycle press and
//   release strobes and an 8-bit press counter. Define
//   BUTTON_CONDITIONER_LONGPRESS_EN to add long-press and auto-repeat
//   strobes; without it long_pulse and repeat_pulse are tied low.
//
//   state        | meaning
//   IDLE         | released and stable
//   PRESS_WAIT   | pressed level seen, counting toward acceptance
//   HELD         | press accepted, level stable
//   RELEASE_WAIT | released level seen while held, counting toward acceptance
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 240000,
  parameter int unsigned LONG_CYCLES     = 12000000,
  parameter int unsigned REPEAT_CYCLES   = 2400000,
  parameter int unsigned CNT_W           = 24,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic [7:0] press_count,
  output logic       long_pulse,
  output logic       repeat_pulse
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             pressed;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic [7:0]       count_q, count_d;

  // Two-flop synchronizer; both flops reset to the released pin level so a
  // button held through reset produces an ordinary debounced press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= BTN_ACTIVE_LOW;
      sync2_q <= BTN_ACTIVE_LOW;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
    end
  end

  assign pressed = sync2_q ^ BTN_ACTIVE_LOW;

  // Debounce state, counter, level, strobes and press counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      dcnt_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      count_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      dcnt_q    <= dcnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      count_q   <= count_d;
    end
  end

  // Debounce next-state: a new level must persist for DEBOUNCE_CYCLES
  // counts in the wait state; any reversal aborts silently.
  always_comb begin
    state_d   = state_q;
    dcnt_d    = dcnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    count_d   = count_q;
    case (state_q)
      IDLE: begin
        if (pressed) begin
          state_d = PRESS_WAIT;
          dcnt_d  = '0;
        end
      end
      PRESS_WAIT: begin
        if (!pressed) begin
          state_d = IDLE;
        end else if (dcnt_q == DEB_LAST) begin
          state_d = HELD;
          press_d = 1'b1;
          level_d = 1'b1;
          count_d = count_q + 8'd1;
        end else begin
          dcnt_d = dcnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!pressed) begin
          state_d = RELEASE_WAIT;
          dcnt_d  = '0;
        end
      end
      RELEASE_WAIT: begin
        if (pressed) begin
          state_d = HELD;
        end else if (dcnt_q == DEB_LAST) begin
          state_d   = IDLE;
          release_d = 1'b1;
          level_d   = 1'b0;
        end else begin
          dcnt_d = dcnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign press_count   = count_q;

`ifdef BUTTON_CONDITIONER_LONGPRESS_EN
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  logic             in_hold;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic             armed_q, armed_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;

  assign in_hold = (state_q == HELD) || (state_q == RELEASE_WAIT);

  // Hold-time, repeat-interval and arm registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt_q   <= '0;
      rcnt_q   <= '0;
      armed_q  <= 1'b0;
      long_q   <= 1'b0;
      repeat_q <= 1'b0;
    end else begin
      hcnt_q   <= hcnt_d;
      rcnt_q   <= rcnt_d;
      armed_q  <= armed_d;
      long_q   <= long_d;
      repeat_q <= repeat_d;
    end
  end

  // Long-press fires once per press; the arm guard also keeps a saturated
  // hold counter from re-triggering it. Release acceptance wins over repeat.
  always_comb begin
    hcnt_d   = hcnt_q;
    rcnt_d   = rcnt_q;
    armed_d  = armed_q;
    long_d   = 1'b0;
    repeat_d = 1'b0;
    if (press_d) begin
      hcnt_d = '0;
    end else if (in_hold && (hcnt_q != {CNT_W{1'b1}})) begin
      hcnt_d = hcnt_q + CNT_W'(1);
    end
    if (release_d) begin
      armed_d = 1'b0;
      rcnt_d  = '0;
    end else if ((state_q == HELD) && (hcnt_q == LONG_LAST) && !armed_q) begin
      long_d  = 1'b1;
      armed_d = 1'b1;
      rcnt_d  = '0;
    end else if (armed_q && in_hold) begin
      if (rcnt_q == REP_LAST) begin
        repeat_d = 1'b1;
        rcnt_d   = '0;
      end else begin
        rcnt_d = rcnt_q + CNT_W'(1);
      end
    end
  end

  assign long_pulse   = long_q;
  assign repeat_pulse = repeat_q;
`else
  assign long_pulse   = 1'b0;
  assign repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Testbench for button_conditioner: a reference model of the debounce rules
// queues expected strobes; a negedge monitor pops and compares them.
module tb_button_conditioner;

  localparam int D = 4;
  localparam int L = 20;
  localparam int R = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_in = 1'b1;
  logic       btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse;
  logic [7:0] press_count;

  button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES    (L),
    .REPEAT_CYCLES  (R),
    .CNT_W          (24),
    .BTN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_in       (btn_in),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .press_count  (press_count),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] kind;   // {press, release, long, repeat}
    int         cyc;
    int         cnt;
  } ev_t;

  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  ev_t exp_q[$];

  int  n_press = 0, n_rel = 0, n_long = 0, n_rep = 0;

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: the debounced level flips once the delayed pin has
  // disagreed with it for D+1 consecutive clock edges.
  bit  dly[$];
  bit  mlevel;
  bit  pr;
  bit  armed;
  int  run, prev_run, mcount, age, rc;
  ev_t me;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      dly.delete();
      dly.push_back(1'b1);
      dly.push_back(1'b1);
      mlevel = 1'b0;
      run = 0;
      mcount = 0;
      armed = 1'b0;
      rc = 0;
      age = 0;
      exp_q.delete();
    end else begin
      pr = (dly.pop_front() == 1'b0);
      dly.push_back(btn_in);
      prev_run = run;
      if (pr != mlevel) run++;
      else run = 0;
      if (run == D + 1) begin
        run = 0;
        mlevel = pr;
        me.cyc = cyc;
        if (pr) begin
          mcount = (mcount + 1) % 256;
          age = 0;
          me.kind = 4'b1000;
        end else begin
          armed = 1'b0;
          rc = 0;
          me.kind = 4'b0100;
        end
        me.cnt = mcount;
        exp_q.push_back(me);
      end
`ifdef BUTTON_CONDITIONER_LONGPRESS_EN
      else if (mlevel) begin
        age++;
        me.cyc = cyc;
        me.cnt = mcount;
        if (age == L && prev_run == 0 && !armed) begin
          armed = 1'b1;
          rc = 0;
          me.kind = 4'b0010;
          exp_q.push_back(me);
        end else if (armed) begin
          rc++;
          if (rc == R) begin
            rc = 0;
            me.kind = 4'b0001;
            exp_q.push_back(me);
          end
        end
      end
`endif
    end
  end

  // Monitor: compare level/count every cycle, pop the scoreboard on strobes.
  logic [3:0] obs;
  ev_t        got;
  always @(negedge clk) begin
    if (!rst) begin
      obs = {press_pulse, release_pulse, long_pulse, repeat_pulse};
      if (press_pulse)   n_press++;
      if (release_pulse) n_rel++;
      if (long_pulse)    n_long++;
      if (repeat_pulse)  n_rep++;
      chk("btn_level", int'(btn_level), int'(mlevel));
      chk("press_count", int'(press_count), mcount);
      if (obs != 4'b0000 || (exp_q.size() > 0 && exp_q[0].cyc <= cyc)) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", int'(obs), 0);
        end else begin
          got = exp_q.pop_front();
          chk("pulse_kind", int'(obs), int'(got.kind));
          chk("pulse_cycle", cyc, got.cyc);
          chk("pulse_count", int'(press_count), got.cnt);
        end
      end
    end
  end

  task automatic hold(bit v, int n);
    @(posedge clk);
    #1 btn_in = v;
    repeat (n - 1) @(posedge clk);
  endtask

  function automatic bit sig(int which);
    case (which)
      0: return press_pulse;
      1: return release_pulse;
      2: return long_pulse;
      default: return repeat_pulse;
    endcase
  endfunction

  task automatic wait_sig(int which, int budget, string name, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sig(which)) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) chk({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  int t0, at, at2, at3, c0, r0, p0;

  initial begin
    // Reset state while rst is asserted, button released.
    @(negedge clk);
    chk("rst_level", int'(btn_level), 0);
    chk("rst_count", int'(press_count), 0);
    chk("rst_pulses", int'({press_pulse, release_pulse, long_pulse, repeat_pulse}), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (50) @(posedge clk);
    @(negedge clk);
    chk("idle_level", int'(btn_level), 0);
    chk("idle_count", int'(press_count), 0);
    chk("idle_no_pulses", n_press + n_rel, 0);

    // Clean press and release latency.
    hold(1'b0, 1);
    t0 = cyc + 1;
    wait_sig(0, 30, "press", at);
    chk("press_latency", at - t0, 6);
    chk("press_level", int'(btn_level), 1);
    chk("press_count_1", int'(press_count), 1);
    @(negedge clk);
    chk("press_width", int'(press_pulse), 0);
    hold(1'b1, 1);
    t0 = cyc + 1;
    wait_sig(1, 30, "release", at);
    chk("release_latency", at - t0, 6);
    chk("release_level", int'(btn_level), 0);
    hold(1'b1, 10);

    // Press glitch rejected.
    c0 = n_press;
    hold(1'b0, 3);
    hold(1'b1, 20);
    chk("bounce_press", n_press, c0);
    chk("bounce_count", int'(press_count), 1);

    // Release glitch rejected.
    hold(1'b0, 1);
    wait_sig(0, 30, "press2", at);
    r0 = n_rel;
    hold(1'b1, 3);
    hold(1'b0, 20);
    chk("bounce_release", n_rel, r0);
    hold(1'b1, 20);

    // Random bouncing segments.
    for (int i = 0; i < 150; i++)
      hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 12)));
    hold(1'b1, 20);

    // Wrap of the press counter.
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    p0 = n_press;
    r0 = n_rel;
    for (int i = 0; i < 256; i++) begin
      hold(1'b0, 8);
      hold(1'b1, 8);
    end
    hold(1'b1, 4);
    @(negedge clk);
    chk("wrap_presses", n_press - p0, 256);
    chk("wrap_releases", n_rel - r0, 256);
    chk("wrap_count", int'(press_count), 0);

`ifdef BUTTON_CONDITIONER_LONGPRESS_EN
    hold(1'b0, 1);
    wait_sig(0, 30, "lp_press", at);
    wait_sig(2, 40, "long", at2);
    chk("long_delay", at2 - at, 20);
    wait_sig(3, 20, "repeat1", at3);
    chk("repeat1_delay", at3 - at2, 6);
    wait_sig(3, 20, "repeat2", at);
    chk("repeat2_delay", at - at3, 6);
    hold(1'b1, 1);
    wait_sig(1, 30, "lp_release", at);
    c0 = n_rep;
    hold(1'b1, 40);
    chk("no_repeat_after_release", n_rep, c0);
`else
    chk("long_absent", n_long + n_rep, 0);
`endif

    // Reset while held.
    hold(1'b0, 1);
    wait_sig(0, 30, "held_press", at);
    hold(1'b0, 4);
    r0 = n_rel;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_level", int'(btn_level), 0);
    chk("midrst_count", int'(press_count), 0);
    chk("midrst_pulses", int'({press_pulse, release_pulse, long_pulse, repeat_pulse}), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    t0 = cyc + 1;
    wait_sig(0, 30, "post_rst_press", at);
    chk("post_rst_latency", at - t0, 6);
    chk("post_rst_count", int'(press_count), 1);
    chk("midrst_no_release", n_rel, r0);
    hold(1'b1, 20);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Input-side counterpart to the LED drive path: conditions the raw board BUTTON pin into clean, single-cycle event pulses for application logic.
- Contains a 2-FF synchronizer, a debounce state machine, a stable level output and an 8-bit press counter.
- Optional long-press / auto-repeat detection.
- Sits between the BUTTON pad and any logic clocked by Sys_Clk0.

Parameters:
- DEBOUNCE_CYCLES, 240000: cycles the synchronized input must hold a new value before it is accepted (20 ms at 12 MHz); legal range 1..2^CNT_W-1.
- LONG_CYCLES, 12000000: cycles held, counted from press acceptance, before long_pulse fires (used only with the optional feature).
- REPEAT_CYCLES, 2400000: interval between repeat_pulse strobes after a long press (used only with the optional feature).
- CNT_W, 24: width of the internal counters.
- BTN_ACTIVE_LOW, 1: 1 = pressed when pin is 0; 0 = pressed when pin is 1.

Ports:
- clk  in  1  system clock (Sys_Clk0)
- rst  in  1  reset, asynchronous, active-high
- btn_in  in  1  raw asynchronous button pin
- btn_level  out  1  debounced state, 1 = pressed
- press_pulse  out  1  one-cycle strobe when a press is accepted
- release_pulse  out  1  one-cycle strobe when a release is accepted
- press_count  out  8  accepted presses, wraps at 255 -> 0
- long_pulse  out  1  one-cycle long-press strobe (tied 0 without the feature)
- repeat_pulse  out  1  one-cycle auto-repeat strobe (tied 0 without the feature)

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-high. All registers reset.
- Reset values:
  - Both synchronizer flops hold the released pin level (1 if BTN_ACTIVE_LOW, else 0), so leaving reset with the button held yields a normal debounced press, never a glitch.
  - FSM = IDLE; counters = 0; btn_level = 0; all pulses = 0; press_count = 0.
- Synchronizer: btn_in -> s1 -> s2. p = s2 XOR BTN_ACTIVE_LOW (p = 1 means pressed).
- FSM:
  - IDLE: if p = 1, go to PRESS_WAIT with dcnt = 0.
  - PRESS_WAIT:
    - if p = 0, return to IDLE (glitch rejected, no output);
    - else if dcnt = DEBOUNCE_CYCLES-1, go to HELD; press_pulse = 1 for that cycle; btn_level = 1; press_count += 1; hcnt = 0;
    - else dcnt += 1.
  - HELD: if p = 0, go to RELEASE_WAIT with dcnt = 0. hcnt increments, saturating at all-ones.
  - RELEASE_WAIT:
    - if p = 1, return to HELD (hcnt continues, no pulses);
    - else if dcnt = DEBOUNCE_CYCLES-1, go to IDLE; release_pulse = 1; btn_level = 0;
    - else dcnt += 1.
- Latency: an input edge held stable produces its pulse DEBOUNCE_CYCLES+2 cycles after the edge (2 synchronizer cycles + debounce count). btn_level changes in the same cycle as the corresponding pulse.
- Pulses:
  - registered outputs, high for exactly one cycle;
  - press_pulse and release_pulse are never high together;
  - no pulse ever fires in PRESS_WAIT-abort or RELEASE_WAIT-abort paths.
- Reset mid-operation: all state is cleared immediately. No release_pulse is emitted for a press that was in progress.
- Counter widths: compares are done at CNT_W bits. Parameters must fit in CNT_W; a value that does not fit is a parameter error, not a run-time case.

Optional Feature:
- Macro: BUTTON_CONDITIONER_LONGPRESS_EN.
- Defined:
  - In HELD, when hcnt = LONG_CYCLES-1, long_pulse fires once, rcnt = 0, and repeat mode is armed.
  - While armed and still in HELD or RELEASE_WAIT, repeat_pulse fires each time rcnt reaches REPEAT_CYCLES-1; rcnt then resets to 0.
  - Accepted release (entering IDLE) disarms repeat mode and clears rcnt. A bounce back to HELD keeps repeat mode armed.
  - At most one of long_pulse and repeat_pulse is high in any cycle.
- Undefined: long_pulse = 0, repeat_pulse = 0; hcnt and repeat logic are absent.

Test Plan:
- Bench parameters: DEBOUNCE_CYCLES = 4, LONG_CYCLES = 20, REPEAT_CYCLES = 6, BTN_ACTIVE_LOW = 1.
- Reset release with btn_in = 1: hold 50 cycles -> btn_level = 0; no pulses; press_count = 0.
- btn_in falls and stays 0 -> press_pulse exactly 6 cycles after the edge, width 1; btn_level = 1; press_count = 1. btn_in then rises -> release_pulse 6 cycles later; btn_level = 0.
- Bounce: btn_in low for 3 cycles, then high -> no press_pulse, press_count unchanged. Same test on release: a 3-cycle high glitch while pressed -> no release_pulse.
- 256 clean press/release pairs -> press_count wraps to 0; exactly 256 press_pulse and 256 release_pulse seen.
- With BUTTON_CONDITIONER_LONGPRESS_EN: hold pressed -> long_pulse 20 cycles after press_pulse; repeat_pulse every 6 cycles thereafter. After release is accepted -> no further repeats.
- Assert rst for 1 cycle while in HELD with btn_in = 0 -> outputs return to reset values at once, no release_pulse. After rst falls, a fresh press_pulse arrives 6 cycles later and press_count = 1.
